vending_credit_engine: RTL

VENDING_CREDIT_ENGINE -- requirements
Module: vending_credit_engine

---
 rtl/vending_credit_engine_pkg.sv | 27 ++
 rtl/vm_change_select.sv | 39 +++
 rtl/vending_credit_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/vending_credit_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vending_credit_engine_pkg
// Brief    : shared FSM states, default constants and width helper
// Revision : 1.0
// ============================================================================
package vending_credit_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RETURN = 2'd2
  } vm_state_e;

  localparam int         C_NUM_COINS   = 3;
  localparam int         C_NUM_ITEMS   = 4;
  localparam int         C_TOTAL_BITS  = 31;
  localparam int         C_WAIT_CYCLES = 100;
  localparam logic [7:0] C_STOCK_INIT  = 8'd10;

  // Compare width wide enough for both the credit and a raw 32-bit value, plus carry.
  function automatic int calc_aw(input int total_bits);
    return ((total_bits > 32) ? total_bits : 32) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_change_select.sv
`default_nettype none
// ============================================================================
// Module   : vm_change_select
// Brief    : greedy pick of the largest non-zero coin not exceeding the credit
// Revision : 1.0
// ============================================================================
module vm_change_select
  import vending_credit_engine_pkg::*;
#(
  parameter int NUM_COINS  = C_NUM_COINS,
  parameter int TOTAL_BITS = C_TOTAL_BITS
) (
  input  logic [TOTAL_BITS-1:0]   i_credit,
  input  logic [NUM_COINS*32-1:0] i_coin_value,
  output logic                    o_valid,
  output logic [NUM_COINS-1:0]    o_coin,
  output logic [31:0]             o_value
);

  localparam int AW = calc_aw(TOTAL_BITS);

  // Ascending scan: the last fitting coin is the largest one.
  always_comb begin
    o_valid = 1'b0;
    o_coin  = '0;
    o_value = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if ((i_coin_value[i*32 +: 32] != 32'd0) &&
          (AW'(i_coin_value[i*32 +: 32]) <= AW'(i_credit))) begin
        o_valid   = 1'b1;
        o_coin    = '0;
        o_coin[i] = 1'b1;
        o_value   = i_coin_value[i*32 +: 32];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vending_credit_engine.sv
`default_nettype none
// ============================================================================
// Module   : vending_credit_engine
// Brief    : coin credit, item dispense and greedy change return FSM;
//            optional per-item stock counters under VM_ITEM_STOCK_EN
// Revision : 1.0
// ============================================================================
module vending_credit_engine
  import vending_credit_engine_pkg::*;
#(
  parameter int NUM_COINS   = C_NUM_COINS,
  parameter int NUM_ITEMS   = C_NUM_ITEMS,
  parameter int TOTAL_BITS  = C_TOTAL_BITS,
  parameter int WAIT_CYCLES = C_WAIT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    i_select_item,
  input  logic                    i_trigger_return,
  input  logic [NUM_COINS*32-1:0] i_coin_value,
  input  logic [NUM_ITEMS*32-1:0] i_item_price,
  output logic [NUM_ITEMS-1:0]    o_available_item,
  output logic [NUM_ITEMS-1:0]    o_output_item,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic                    o_coin_reject,
  output logic [TOTAL_BITS-1:0]   o_current_total,
  output logic                    o_busy_return
);

  localparam int AW = calc_aw(TOTAL_BITS);
  localparam int TW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  vm_state_e             r_state, w_state_nxt;
  logic [TOTAL_BITS-1:0] r_total, w_total_nxt;
  logic [TW-1:0]         r_timer, w_timer_nxt;
  logic [NUM_ITEMS-1:0]  r_output_item, w_output_item;
  logic [NUM_COINS-1:0]  r_return_coin, w_return_coin;
  logic                  r_coin_reject, w_coin_reject;

  logic [NUM_ITEMS-1:0]  w_price_ok, w_in_stock, w_avail;
  logic [NUM_ITEMS-1:0]  w_sel_onehot;
  logic [31:0]           w_sel_price, w_coin_val, w_chg_value;
  logic                  w_sel_ok, w_coin_hit, w_coin_ok, w_chg_valid, w_event;
  logic [NUM_COINS-1:0]  w_chg_coin;
  logic [AW-1:0]         w_sum;

  // Prices beyond the credit range compare as unaffordable thanks to the wide compare.
  generate
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
      assign w_price_ok[i] = AW'(r_total) >= AW'(i_item_price[i*32 +: 32]);
    end
  endgenerate

`ifdef VM_ITEM_STOCK_EN
  generate
    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_stock
      logic [7:0] r_stock;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_stock <= C_STOCK_INIT;
        end else if (w_output_item[i] && (r_stock != 8'd0)) begin
          r_stock <= r_stock - 8'd1;
        end
      end
      assign w_in_stock[i] = (r_stock != 8'd0);
    end
  endgenerate
`else
  assign w_in_stock = '1;
`endif

  assign w_avail = w_price_ok & w_in_stock;

  // Lowest-index coin and lowest-index selection win; descending scan lets index 0 overwrite.
  always_comb begin
    w_coin_hit   = 1'b0;
    w_coin_val   = '0;
    w_sel_onehot = '0;
    w_sel_price  = '0;
    for (int i = NUM_COINS - 1; i >= 0; i--) begin
      if (i_input_coin[i]) begin
        w_coin_hit = 1'b1;
        w_coin_val = i_coin_value[i*32 +: 32];
      end
    end
    for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
      if (i_select_item[i]) begin
        w_sel_onehot    = '0;
        w_sel_onehot[i] = 1'b1;
        w_sel_price     = i_item_price[i*32 +: 32];
      end
    end
  end

  assign w_sel_ok  = |(w_sel_onehot & w_avail);
  assign w_sum     = AW'(r_total) + AW'(w_coin_val);
  assign w_coin_ok = w_coin_hit && (w_sum[AW-1:TOTAL_BITS] == '0);
  assign w_event   = w_coin_ok || w_sel_ok;

  vm_change_select #(
    .NUM_COINS  (NUM_COINS),
    .TOTAL_BITS (TOTAL_BITS)
  ) u_change_select (
    .i_credit     (r_total),
    .i_coin_value (i_coin_value),
    .o_valid      (w_chg_valid),
    .o_coin       (w_chg_coin),
    .o_value      (w_chg_value)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_total_nxt   = r_total;
    w_timer_nxt   = r_timer;
    w_output_item = '0;
    w_return_coin = '0;
    w_coin_reject = 1'b0;
    case (r_state)
      ST_IDLE, ST_ACTIVE: begin
        w_coin_reject = w_coin_hit && !w_coin_ok;
        if (w_coin_ok) begin
          w_total_nxt = TOTAL_BITS'(w_sum);
        end
        if (w_sel_ok) begin
          w_total_nxt   = w_total_nxt - TOTAL_BITS'(w_sel_price);
          w_output_item = w_sel_onehot;
        end
        if (w_event) begin
          w_timer_nxt = TW'(WAIT_CYCLES);
          w_state_nxt = ST_ACTIVE;
        end else if ((r_state == ST_ACTIVE) && (r_timer != '0)) begin
          w_timer_nxt = r_timer - TW'(1);
        end
        if (i_trigger_return || ((r_state == ST_ACTIVE) && (r_timer == '0) && !w_event)) begin
          w_state_nxt = (w_total_nxt != '0) ? ST_RETURN : ST_IDLE;
          w_timer_nxt = '0;
        end
      end
      ST_RETURN: begin
        w_coin_reject = w_coin_hit;
        if (w_chg_valid) begin
          w_return_coin = w_chg_coin;
          w_total_nxt   = r_total - TOTAL_BITS'(w_chg_value);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_total       <= '0;
      r_timer       <= '0;
      r_output_item <= '0;
      r_return_coin <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_total       <= w_total_nxt;
      r_timer       <= w_timer_nxt;
      r_output_item <= w_output_item;
      r_return_coin <= w_return_coin;
      r_coin_reject <= w_coin_reject;
    end
  end

  assign o_available_item = w_avail;
  assign o_output_item    = r_output_item;
  assign o_return_coin    = r_return_coin;
  assign o_coin_reject    = r_coin_reject;
  assign o_current_total  = r_total;
  assign o_busy_return    = (r_state == ST_RETURN);

endmodule
`default_nettype wire
